rr_arbiter: RTL and testbench
=============================

# rr_arbiter

Registered round-robin / fixed-priority arbiter that shares one resource among PORTS requesters. It uses the team's priority encoder for the winner pick (masked and unmasked instances) and adds the grant register, the round-robin mask and the grant-hold logic. It sits in front of the AXI interconnect and crossbar address/response paths, where a granted port owns the shared channel until it releases it.

## Interface
- PORTS, 4: number of requesters, ≥1
- ARB_TYPE_ROUND_ROBIN, 1: 1 = round-robin, 0 = fixed priority
- ARB_BLOCK, 1: 1 = hold grant while the winner keeps requesting; 0 = re-arbitrate every cycle
- ARB_BLOCK_ACK, 0: 1 = hold grant until the winner pulses acknowledge (only used when ARB_BLOCK=1)
- ARB_LSB_HIGH_PRIORITY, 1: 1 = lowest index wins ties; 0 = highest index wins
- TIMEOUT, 256: maximum grant-hold cycles, ≥2; used only when RR_ARBITER_TIMEOUT_EN is defined
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- request  input  PORTS  per-port request level
- acknowledge  input  PORTS  per-port release pulse (ARB_BLOCK_ACK mode)
- grant  output  PORTS  one-hot grant, registered
- grant_valid  output  1  any grant active, registered
- grant_encoded  output  $clog2(PORTS) (1 when PORTS=1)  index of the granted port, registered
- timeout  output  1  one-cycle pulse on forced release; constant 0 when the feature is compiled out

## Operation
- Reset values: grant=0, grant_valid=0, grant_encoded=0, timeout=0, mask=0, hold counter=0.
- States:
  - IDLE (grant_valid=0).
  - GRANTED (grant_valid=1, exactly one grant bit set, grant == 1<<grant_encoded).
- Hold conditions in GRANTED:
  - ARB_BLOCK=0: never held; re-arbitrate every edge.
  - ARB_BLOCK=1, ARB_BLOCK_ACK=0: held while request[grant_encoded]=1.
  - ARB_BLOCK=1, ARB_BLOCK_ACK=1: held until acknowledge[grant_encoded]=1. The request level is ignored while held.
- acknowledge bits of non-granted ports are ignored.
- On an edge where the grant is not held (IDLE or released): pick a winner from the current request.
  - If no requests, go to IDLE with grant=0. grant_encoded keeps its last value.
  - Release and new grant happen on the same edge; there is no idle bubble.
- Round-robin pick: take the winner from request & mask if that is non-zero, otherwise from request.
- On each new grant to port k, load mask with the ports after k in priority order: bits above k when ARB_LSB_HIGH_PRIORITY=1, bits below k otherwise.
- Fixed-priority pick: the encoder result on request only. The mask is unused.
- A released port that is still requesting may be regranted only if no other port is requesting (round-robin mode).
- Wrap-around: mask=0 after granting the last port in priority order, so the pick restarts from the top.
- PORTS=1: grant tracks the hold/release rules; grant_encoded is always 0.

## Timing
- Latency: a request sampled at edge N produces grant at edge N (visible the cycle after request is asserted) when the arbiter is free.
- Release: a request dropped (or acknowledge pulsed) before edge N deasserts or moves grant at edge N.
- A request asserted and dropped between two edges is never granted.
- Reset asserted mid-grant clears all outputs immediately, without waiting for clk. The first arbitration happens on the first edge after rst deasserts.
- grant, grant_valid, grant_encoded and timeout are driven directly from flops; there is no combinational path from inputs to outputs.

## Configuration
- RR_ARBITER_TIMEOUT_EN defined:
  - A counter increments each cycle a grant is held and clears on every new grant.
  - On the edge where the counter reaches TIMEOUT-1 with the hold condition still true, the grant is force-released and re-arbitration runs normally (round-robin excludes the current port if others request).
  - timeout pulses high for 1 cycle on that edge.
- Not defined: no counter; grants are held indefinitely; timeout is tied 0.

## Test plan
- Reset: assert rst asynchronously mid-grant, with request=4'b1111 held → grant=0, grant_valid=0 immediately; first edge after deassert gives grant=4'b0001, grant_encoded=0.
- Round-robin: PORTS=4, ARB_BLOCK=0, request=4'b1111 constant → grant sequence 0001, 0010, 0100, 1000, 0001 on consecutive edges.
- Blocking hold: ARB_BLOCK=1, port 2 granted, request=4'b0101 held for 5 cycles → grant stays 0100; drop request[2] → next edge grant=0001.
- Ack mode: ARB_BLOCK_ACK=1, port 1 granted, request[1] dropped but no acknowledge → grant stays 0010; acknowledge[3] pulse is ignored; acknowledge[1] pulse with request=4'b1010 → next edge grant=1000.
- Fixed priority: ARB_TYPE_ROUND_ROBIN=0, request=4'b0110 → grant=0010 every edge; with ARB_LSB_HIGH_PRIORITY=0 → grant=0100.
- Timeout (RR_ARBITER_TIMEOUT_EN, TIMEOUT=8): port 0 held with request=4'b0011 → grant 0001 for 8 cycles, then grant=0010 with timeout=1 for one cycle; sole requester case regrants port 0 with counter restarted.

Source files
------------

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between the requesters (master side) and rr_arbiter (slave side).
interface rr_arbiter_if #(
    parameter int PORTS = 4
);
    localparam int EW = (PORTS > 1) ? $clog2(PORTS) : 1;

    logic [PORTS-1:0] request;
    logic [PORTS-1:0] acknowledge;
    logic [PORTS-1:0] grant;
    logic             grant_valid;
    logic [EW-1:0]    grant_encoded;
    logic             timeout;

    modport master (
        output request,
        output acknowledge,
        input  grant,
        input  grant_valid,
        input  grant_encoded,
        input  timeout
    );

    modport slave (
        input  request,
        input  acknowledge,
        output grant,
        output grant_valid,
        output grant_encoded,
        output timeout
    );
endinterface

// File: rtl/rr_arbiter.sv
// Registered round-robin / fixed-priority arbiter with optional grant hold.
// Define RR_ARBITER_TIMEOUT_EN to add a forced release after TIMEOUT held cycles.

module rr_arbiter_prio_enc #(
    parameter int W        = 4,
    parameter int LSB_HIGH = 1,
    parameter int IW       = 2
) (
    input  logic [W-1:0]  in_bits,
    output logic          valid,
    output logic [IW-1:0] idx
);
    // The last matching bit written wins, so scan from lowest to highest priority.
    always_comb begin
        valid = |in_bits;
        idx   = '0;
        if (LSB_HIGH != 0) begin
            for (int i = W - 1; i >= 0; i--) begin
                if (in_bits[i]) idx = IW'(i);
            end
        end else begin
            for (int i = 0; i < W; i++) begin
                if (in_bits[i]) idx = IW'(i);
            end
        end
    end
endmodule

module rr_arbiter #(
    parameter int PORTS                 = 4,
    parameter int ARB_TYPE_ROUND_ROBIN  = 1,
    parameter int ARB_BLOCK             = 1,
    parameter int ARB_BLOCK_ACK         = 0,
    parameter int ARB_LSB_HIGH_PRIORITY = 1,
    parameter int TIMEOUT               = 256
) (
    input  logic        clk,
    input  logic        rst,
    rr_arbiter_if.slave bus
);
    localparam int EW = (PORTS > 1) ? $clog2(PORTS) : 1;

    if (PORTS < 1 || TIMEOUT < 2) begin : g_bad_cfg
        $error("rr_arbiter: PORTS must be >= 1 and TIMEOUT >= 2");
    end

    typedef enum logic {IDLE = 1'b0, GRANTED = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [PORTS-1:0] grant_q, grant_d;
    logic [PORTS-1:0] mask_q, mask_d;
    logic [EW-1:0]    enc_q, enc_d;
    logic             timeout_q, timeout_d;

    logic [PORTS-1:0] req_masked;
    logic             raw_vld, msk_vld;
    logic [EW-1:0]    raw_idx, msk_idx, pick_idx;
    logic             held, force_rel, hold;

    assign req_masked = bus.request & mask_q;

    rr_arbiter_prio_enc #(.W(PORTS), .LSB_HIGH(ARB_LSB_HIGH_PRIORITY), .IW(EW)) u_enc_raw (
        .in_bits (bus.request),
        .valid   (raw_vld),
        .idx     (raw_idx)
    );

    rr_arbiter_prio_enc #(.W(PORTS), .LSB_HIGH(ARB_LSB_HIGH_PRIORITY), .IW(EW)) u_enc_msk (
        .in_bits (req_masked),
        .valid   (msk_vld),
        .idx     (msk_idx)
    );

    // Ports after the last winner take precedence; fall back to the full set on wrap.
    assign pick_idx = ((ARB_TYPE_ROUND_ROBIN != 0) && msk_vld) ? msk_idx : raw_idx;

    always_comb begin
        held = 1'b0;
        if (state_q == GRANTED && ARB_BLOCK != 0) begin
            if (ARB_BLOCK_ACK != 0) held = !bus.acknowledge[enc_q];
            else                    held = bus.request[enc_q];
        end
    end

`ifdef RR_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0] cnt_q, cnt_d;

    assign force_rel = held && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = '0;
        if (hold) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    assign force_rel = 1'b0;
`endif

    assign hold = held && !force_rel;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        enc_d     = enc_q;
        mask_d    = mask_q;
        timeout_d = force_rel;
        if (!hold) begin
            if (raw_vld) begin
                state_d = GRANTED;
                enc_d   = pick_idx;
                for (int i = 0; i < PORTS; i++) begin
                    grant_d[i] = (i == int'(pick_idx));
                    if (ARB_TYPE_ROUND_ROBIN != 0) begin
                        mask_d[i] = (ARB_LSB_HIGH_PRIORITY != 0) ? (i > int'(pick_idx))
                                                                 : (i < int'(pick_idx));
                    end
                end
            end else begin
                // grant_encoded intentionally keeps the last winner while idle.
                state_d = IDLE;
                grant_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            mask_q    <= '0;
            enc_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            mask_q    <= mask_d;
            enc_q     <= enc_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.grant         = grant_q;
    assign bus.grant_valid   = (state_q == GRANTED);
    assign bus.grant_encoded = enc_q;
    assign bus.timeout       = timeout_q;
endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: six configurations share one stimulus stream and are
// checked every cycle against a cyclic-search reference model.
module tb_rr_arbiter;
    localparam int NI  = 6;
    localparam int P   = 4;
    localparam int TMO = 8;
    //                             A  B  C  D  E  F
    localparam int RR_C  [NI] = '{1, 1, 1, 0, 0, 1};
    localparam int BLK_C [NI] = '{0, 1, 1, 0, 0, 0};
    localparam int ACK_C [NI] = '{0, 0, 1, 0, 0, 0};
    localparam int LSB_C [NI] = '{1, 1, 1, 1, 0, 0};

    logic         clk = 1'b0;
    logic         rst;
    logic [P-1:0] req, ack;

    logic [P-1:0] gnt [NI];
    logic         gv  [NI];
    logic [1:0]   enc [NI];
    logic         to  [NI];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        rr_arbiter_if #(.PORTS(P)) bus ();
        rr_arbiter #(
            .PORTS                 (P),
            .ARB_TYPE_ROUND_ROBIN  (RR_C[g]),
            .ARB_BLOCK             (BLK_C[g]),
            .ARB_BLOCK_ACK         (ACK_C[g]),
            .ARB_LSB_HIGH_PRIORITY (LSB_C[g]),
            .TIMEOUT               (TMO)
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
        assign bus.request     = req;
        assign bus.acknowledge = ack;
        assign gnt[g] = bus.grant;
        assign gv[g]  = bus.grant_valid;
        assign enc[g] = bus.grant_encoded;
        assign to[g]  = bus.timeout;
    end

    // Reference model: owner (-1 = idle), last winner for the cyclic search.
    typedef struct {
        int owner;
        int enc;
        int last;
        int cnt;
        bit to;
    } mst_t;

    mst_t m [NI];

    function automatic int pick(input int n, input logic [P-1:0] r, input int last);
        int i;
        if (r == '0) return -1;
        if (RR_C[n] != 0) begin
            for (int s = 1; s <= P; s++) begin
                i = (LSB_C[n] != 0) ? (last + s) % P : (last - s + P) % P;
                if (r[i]) return i;
            end
        end else if (LSB_C[n] != 0) begin
            for (int k = 0; k < P; k++) if (r[k]) return k;
        end else begin
            for (int k = P - 1; k >= 0; k--) if (r[k]) return k;
        end
        return -1;
    endfunction

    function automatic mst_t reset_val(input int n);
        mst_t s;
        s.owner = -1;
        s.enc   = 0;
        s.last  = (LSB_C[n] != 0) ? P - 1 : 0;
        s.cnt   = 0;
        s.to    = 1'b0;
        return s;
    endfunction

    function automatic mst_t next_state(input int n, input mst_t s,
                                        input logic [P-1:0] r, input logic [P-1:0] a);
        mst_t ns;
        bit hold, fr;
        int w;
        ns   = s;
        hold = 1'b0;
        fr   = 1'b0;
        if (s.owner >= 0 && BLK_C[n] != 0)
            hold = (ACK_C[n] != 0) ? !a[s.owner] : r[s.owner];
`ifdef RR_ARBITER_TIMEOUT_EN
        if (hold && s.cnt == TMO - 1) fr = 1'b1;
`endif
        ns.to = fr;
        if (hold && !fr) begin
            ns.cnt = s.cnt + 1;
        end else begin
            ns.cnt   = 0;
            w        = pick(n, r, s.last);
            ns.owner = w;
            if (w >= 0) begin
                ns.enc = w;
                if (RR_C[n] != 0) ns.last = w;
            end
        end
        return ns;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int n = 0; n < NI; n++) begin
            if (rst) m[n] <= reset_val(n);
            else     m[n] <= next_state(n, m[n], req, ack);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int n = 0; n < NI; n++) begin
            chk($sformatf("u%0d.grant", n), 32'(gnt[n]),
                (m[n].owner >= 0) ? (32'd1 << m[n].owner) : 32'd0);
            chk($sformatf("u%0d.grant_valid", n), 32'(gv[n]), 32'(m[n].owner >= 0));
            chk($sformatf("u%0d.grant_encoded", n), 32'(enc[n]), 32'(m[n].enc));
            chk($sformatf("u%0d.timeout", n), 32'(to[n]), 32'(m[n].to));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [P-1:0] tv_req [16] = '{4'b1111, 4'b1011, 4'b0111, 4'b0000, 4'b1100, 4'b1100, 4'b0011, 4'b1001,
                                  4'b1110, 4'b0101, 4'b0101, 4'b1010, 4'b0000, 4'b1111, 4'b0110, 4'b1000};
    logic [P-1:0] tv_ack [16] = '{4'b0000, 4'b0001, 4'b0010, 4'b0000, 4'b0100, 4'b1000, 4'b0001, 4'b0000,
                                  4'b0010, 4'b0100, 4'b0001, 4'b1000, 4'b0000, 4'b1111, 4'b0000, 4'b0010};
    logic [P-1:0] exp_a [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [P-1:0] exp_f [5] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};

    initial begin
        rst = 1'b1;
        req = '0;
        ack = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.grant", 32'(gnt[1]), 32'd0);
        chk("reset.grant_valid", 32'(gv[1]), 32'd0);
        chk("reset.timeout", 32'(to[1]), 32'd0);

        // Round-robin rotation in both priority directions.
        rst = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("rr_lsb.edge%0d", i), 32'(gnt[0]), 32'(exp_a[i]));
            chk($sformatf("rr_msb.edge%0d", i), 32'(gnt[5]), 32'(exp_f[i]));
            if (i == 0) begin
                chk("first.block.grant", 32'(gnt[1]), 32'b0001);
                chk("first.fixed_msb.grant", 32'(gnt[4]), 32'b1000);
            end
        end

        // Asynchronous reset in the middle of a cycle.
        #2 rst = 1'b1;
        #1;
        chk("async_rst.grant", 32'(gnt[1]), 32'd0);
        chk("async_rst.grant_valid", 32'(gv[1]), 32'd0);
        chk("async_rst.rr.grant", 32'(gnt[0]), 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst.grant", 32'(gnt[1]), 32'b0001);
        chk("post_rst.grant_encoded", 32'(enc[1]), 32'd0);

        // Blocking hold on port 2, then release.
        req = 4'b0100;
        step();
        chk("block.take2", 32'(gnt[1]), 32'b0100);
        req = 4'b0101;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("block.hold%0d", i), 32'(gnt[1]), 32'b0100);
        end
        req = 4'b0001;
        step();
        chk("block.release", 32'(gnt[1]), 32'b0001);

        // Ack mode: move to port 1, ignore dropped request and foreign ack.
        req = 4'b0010;
        ack = 4'b0001;
        step();
        chk("ack.take1", 32'(gnt[2]), 32'b0010);
        ack = 4'b0000;
        req = 4'b0000;
        repeat (2) begin
            step();
            chk("ack.hold_noreq", 32'(gnt[2]), 32'b0010);
        end
        ack = 4'b1000;
        step();
        chk("ack.foreign_ack", 32'(gnt[2]), 32'b0010);
        ack = 4'b0010;
        req = 4'b1010;
        step();
        chk("ack.release", 32'(gnt[2]), 32'b1000);
        ack = 4'b0000;

        // Fixed priority in both directions.
        req = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fixed_lsb.grant", 32'(gnt[3]), 32'b0010);
            chk("fixed_msb.grant", 32'(gnt[4]), 32'b0100);
        end

        // A request pulse between two edges is never granted.
        req = 4'b0000;
        step();
        #2 req = 4'b1000;
        #3 req = 4'b0000;
        step();
        chk("glitch.grant_valid", 32'(gv[0]), 32'd0);
        chk("glitch.grant", 32'(gnt[0]), 32'd0);

        // Mixed vectors; the model carries the checking.
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < 16; i++) begin
                req = tv_req[i];
                ack = tv_ack[i];
                step();
            end
        end
        req = '0;
        ack = '0;
        step();

`ifdef RR_ARBITER_TIMEOUT_EN
        rst = 1'b1;
        req = 4'b0011;
        step();
        rst = 1'b0;
        step();
        chk("tmo.grant0", 32'(gnt[1]), 32'b0001);
        for (int i = 0; i < 7; i++) begin
            step();
            chk("tmo.hold0", 32'(gnt[1]), 32'b0001);
            chk("tmo.no_pulse", 32'(to[1]), 32'd0);
        end
        step();
        chk("tmo.move", 32'(gnt[1]), 32'b0010);
        chk("tmo.pulse", 32'(to[1]), 32'd1);
        step();
        chk("tmo.pulse_end", 32'(to[1]), 32'd0);
        req = 4'b0001;
        step();
        chk("tmo.sole_grant", 32'(gnt[1]), 32'b0001);
        for (int i = 0; i < 7; i++) begin
            step();
            chk("tmo.sole_no_pulse", 32'(to[1]), 32'd0);
        end
        step();
        chk("tmo.sole_regrant", 32'(gnt[1]), 32'b0001);
        chk("tmo.sole_pulse", 32'(to[1]), 32'd1);
        step();
        chk("tmo.sole_pulse_end", 32'(to[1]), 32'd0);
        req = '0;
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
